// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM link blocks (receive demux, future transmit mux).
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  localparam int SYNC_SLOT = 0;

  // Slot index width; a 2-channel link still needs one bit of index.
  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear, load-to-1 (sync beat consumed slot 0), increment with wrap at N-1.
module tdm_slot_ctr #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] cnt
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SW'(1);
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: steers slot words into shadow registers and
// publishes each complete frame on dout with a one-cycle dout_vld strobe.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N_CH = 2,
  parameter  int W    = 1,
  localparam int SW   = slot_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      din,
  input  logic              din_vld,
  input  logic              fsync,
  output logic [N_CH*W-1:0] dout,
  output logic              dout_vld,
  output logic [SW-1:0]     slot,
  output logic              locked,
  output logic              frame_err
);

  localparam logic [SW-1:0] SYNC_IDX  = SW'(SYNC_SLOT);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

  tdm_state_e state, state_next;

  logic          ctr_clr, ctr_load1, ctr_inc;
  logic          wr_en;
  logic [SW-1:0] wr_idx;
  logic          frame_done, sync_err;

  // The last slot goes straight into dout, so only N_CH-1 words need holding.
  logic [W-1:0]      shadow [N_CH-1];
  logic [N_CH*W-1:0] frame_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (din_vld) begin
      case (state)
        HUNT: if (fsync) state_next = RUN;
        RUN:  if (!fsync && slot == SYNC_IDX) state_next = HUNT;
      endcase
    end
  end

  always_comb begin
    ctr_clr    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_inc    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = SYNC_IDX;
    frame_done = 1'b0;
    sync_err   = 1'b0;
    if (din_vld) begin
      case (state)
        HUNT: begin
          if (fsync) begin
            ctr_load1 = 1'b1;
            wr_en     = 1'b1;
          end
        end
        RUN: begin
          if (fsync && slot != SYNC_IDX) begin
            sync_err  = 1'b1;
            ctr_load1 = 1'b1;
            wr_en     = 1'b1;
          end else if (!fsync && slot == SYNC_IDX) begin
            sync_err = 1'b1;
            ctr_clr  = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_idx     = slot;
            ctr_inc    = 1'b1;
            frame_done = (slot == LAST_SLOT);
          end
        end
      endcase
    end
  end

  tdm_slot_ctr #(
    .N  (N_CH),
    .SW (SW)
  ) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .inc   (ctr_inc),
    .cnt   (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH - 1; k++) shadow[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH - 1; k++) begin
        if (wr_en && wr_idx == SW'(k)) shadow[k] <= din;
      end
    end
  end

  always_comb begin
    frame_next = '0;
    for (int k = 0; k < N_CH - 1; k++) frame_next[k*W +: W] = shadow[k];
    frame_next[(N_CH-1)*W +: W] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dout_vld  <= frame_done;
      frame_err <= sync_err;
      if (frame_done) dout <= frame_next;
    end
  end

  assign locked = (state == RUN);

endmodule
